rasterizer_vertex_writeback: RTL and testbench

//  Avalon-MM write master that stores 4-word vertices (x, y, z, w) to SDRAM.

---
 rtl/rasterizer_pkg.sv | 37 +++
 rtl/rasterizer_vertex_fifo.sv | 75 +++++++
 rtl/rasterizer_vertex_writeback.sv | 167 ++++++++++++++++
 tb/tb_rasterizer_vertex_writeback.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rasterizer_pkg.sv
// -----------------------------------------------------------------------------
// rasterizer_pkg
//   Shared types and constants for the rasterizer vertex paths.
//   - VERTEX_WORDS / ADDR_W / DATA_W : vertex geometry and Avalon widths
//   - vertex_t   : four 32-bit words, index 0 = x (stored at base+0)
//   - wb_entry_t : one queued write-back job (byte base address + vertex)
//   - wb_state_t : write-back FSM states
//   - word_addr  : base + 4*idx, modulo 2^ADDR_W
// -----------------------------------------------------------------------------
package rasterizer_pkg;

    localparam int VERTEX_WORDS = 4;
    localparam int ADDR_W       = 26;
    localparam int DATA_W       = 32;

    typedef logic [VERTEX_WORDS-1:0][DATA_W-1:0] vertex_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        vertex_t           vertex;
    } wb_entry_t;

    typedef enum logic [0:0] {
        WB_IDLE  = 1'b0,
        WB_WRITE = 1'b1
    } wb_state_t;

    // Byte address of word idx of a vertex. The sum wraps silently at 2^ADDR_W,
    // and the low two bits of base pass through untouched.
    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [ADDR_W-1:0] base,
        input logic [1:0]        idx
    );
        return base + {{(ADDR_W-4){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/rasterizer_vertex_fifo.sv
// -----------------------------------------------------------------------------
// rasterizer_vertex_fifo
//   Synchronous show-ahead FIFO of wb_entry_t jobs.
//   Ports:
//     clock, reset      : clock, synchronous active-high reset
//     push, push_data   : write an entry (ignored when full)
//     pop               : drop the head entry (ignored when empty)
//     head              : current head entry, valid whenever !empty
//     full, empty, count: occupancy status
// -----------------------------------------------------------------------------
module rasterizer_vertex_fifo
    import rasterizer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  wb_entry_t              push_data,
    input  logic                   pop,
    output wb_entry_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full  = (r_count == FULL_COUNT);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // NOTE: the storage array is deliberately not reset; the pointers and count
    // define which slots hold valid data, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rasterizer_vertex_writeback.sv
// -----------------------------------------------------------------------------
// rasterizer_vertex_writeback
//   Avalon-MM write master that stores 4-word vertices (x, y, z, w) to SDRAM.
//   Vertices are queued in a small FIFO and drained as four single-word
//   writes at base+0, +4, +8, +12.
//   Ports:
//     clock, reset          : sole clock, synchronous active-high reset
//     store_valid/ready     : input handshake (ready = FIFO not full)
//     addr_in, vertex_in    : vertex byte base address and its four words
//     master_*              : Avalon-MM master (write only, all registered)
//     store_busy            : FIFO non-empty or a vertex being written
//     vertex_done           : one-cycle pulse when a vertex's last word is taken
//     vertex_count          : vertices fully written since reset (wraps)
// -----------------------------------------------------------------------------
module rasterizer_vertex_writeback
    import rasterizer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              store_valid,
    output logic              store_ready,
    input  logic [ADDR_W-1:0] addr_in,
    input  vertex_t           vertex_in,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_write,
    output logic              master_read,
    output logic [3:0]        master_byteenable,
    output logic [DATA_W-1:0] master_writedata,
    input  logic              master_waitrequest,
    output logic              store_busy,
    output logic              vertex_done,
    output logic [15:0]       vertex_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // FIFO interface
    wb_entry_t  w_push_entry;
    wb_entry_t  w_head;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [CNT_W-1:0] w_fifo_count;

    // Registered state and Avalon outputs
    wb_state_t         r_state;
    logic [1:0]        r_idx;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_writedata;
    logic              r_write;
    logic              r_done;
    logic [15:0]       r_vertex_count;

    // Next-state values
    wb_state_t         w_state_next;
    logic [1:0]        w_idx_next;
    logic [ADDR_W-1:0] w_address_next;
    logic [DATA_W-1:0] w_writedata_next;
    logic              w_write_next;
    logic              w_done_next;
    logic [15:0]       w_vertex_count_next;
    logic [1:0]        w_idx_inc;

    // ready depends on full only, so a full FIFO never accepts even when it
    // pops in the same cycle; this keeps ready free of any Avalon-side path.
    assign store_ready  = !w_full;
    assign w_push       = store_valid && !w_full;
    assign w_push_entry = '{addr: addr_in, vertex: vertex_in};

    rasterizer_vertex_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_fifo_count)
    );

    assign w_idx_inc = r_idx + 2'd1;

    // The head entry stays in the FIFO until its last word is accepted, so the
    // show-ahead head doubles as the current vertex; no separate copy is kept.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_next        = r_state;
        w_idx_next          = r_idx;
        w_address_next      = r_address;
        w_writedata_next    = r_writedata;
        w_write_next        = r_write;
        w_done_next         = 1'b0;
        w_vertex_count_next = r_vertex_count;
        w_pop               = 1'b0;

        case (r_state)
            WB_IDLE: begin
                if (!w_empty) begin
                    w_write_next     = 1'b1;
                    w_address_next   = w_head.addr;
                    w_writedata_next = w_head.vertex[0];
                    w_idx_next       = 2'd0;
                    w_state_next     = WB_WRITE;
                end
            end
            WB_WRITE: begin
                // While stalled the defaults hold address, data and write.
                if (!master_waitrequest) begin
                    if (r_idx == 2'd3) begin
                        w_pop               = 1'b1;
                        w_write_next        = 1'b0;
                        w_done_next         = 1'b1;
                        w_vertex_count_next = r_vertex_count + 16'd1;
                        w_state_next        = WB_IDLE;
                    end else begin
                        w_idx_next       = w_idx_inc;
                        w_address_next   = word_addr(w_head.addr, w_idx_inc);
                        w_writedata_next = w_head.vertex[w_idx_inc];
                    end
                end
            end
            default: begin
                w_state_next = WB_IDLE;
                w_write_next = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= WB_IDLE;
            r_idx          <= 2'd0;
            r_address      <= '0;
            r_writedata    <= '0;
            r_write        <= 1'b0;
            r_done         <= 1'b0;
            r_vertex_count <= 16'd0;
        end else begin
            r_state        <= w_state_next;
            r_idx          <= w_idx_next;
            r_address      <= w_address_next;
            r_writedata    <= w_writedata_next;
            r_write        <= w_write_next;
            r_done         <= w_done_next;
            r_vertex_count <= w_vertex_count_next;
        end
    end

    assign master_address    = r_address;
    assign master_writedata  = r_writedata;
    assign master_write      = r_write;
    assign master_read       = 1'b0;
    assign master_byteenable = 4'b1111;
    assign vertex_done       = r_done;
    assign vertex_count      = r_vertex_count;
    assign store_busy        = (w_fifo_count != '0) || (r_state == WB_WRITE);

endmodule

// File: tb/tb_rasterizer_vertex_writeback.sv
module tb_rasterizer_vertex_writeback;
    import rasterizer_pkg::*;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              store_valid = 1'b0;
    logic              store_ready;
    logic [ADDR_W-1:0] addr_in = '0;
    vertex_t           vertex_in = '0;
    logic [ADDR_W-1:0] master_address;
    logic              master_write;
    logic              master_read;
    logic [3:0]        master_byteenable;
    logic [DATA_W-1:0] master_writedata;
    logic              master_waitrequest = 1'b0;
    logic              store_busy;
    logic              vertex_done;
    logic [15:0]       vertex_count;

    rasterizer_vertex_writeback #(
        .FIFO_DEPTH (4)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .store_valid        (store_valid),
        .store_ready        (store_ready),
        .addr_in            (addr_in),
        .vertex_in          (vertex_in),
        .master_address     (master_address),
        .master_write       (master_write),
        .master_read        (master_read),
        .master_byteenable  (master_byteenable),
        .master_writedata   (master_writedata),
        .master_waitrequest (master_waitrequest),
        .store_busy         (store_busy),
        .vertex_done        (vertex_done),
        .vertex_count       (vertex_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- write monitor (samples on the falling edge) ----------------
    logic [ADDR_W-1:0] acc_addr [$];
    logic [DATA_W-1:0] acc_data [$];
    int                acc_cyc  [$];
    int                done_cnt = 0;

    logic              prev_stalled = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] prev_data = '0;

    always @(negedge clock) begin
        if (reset) begin
            prev_stalled = 1'b0;
        end else begin
            if (prev_stalled) begin
                check("stall_write_held", 32'(master_write), 32'd1);
                check("stall_addr_held", 32'(master_address), 32'(prev_addr));
                check("stall_data_held", master_writedata, prev_data);
            end
            if (master_write && !master_waitrequest) begin
                acc_addr.push_back(master_address);
                acc_data.push_back(master_writedata);
                acc_cyc.push_back(cyc);
            end
            if (vertex_done) done_cnt++;
            prev_stalled = master_write && master_waitrequest;
            prev_addr    = master_address;
            prev_data    = master_writedata;
        end
    end

    // ---------------- waitrequest generator ----------------
    bit hold_wait   = 1'b0;
    int stall_word  = -1;
    int stall_left  = 0;

    always begin
        @(posedge clock);
        #1;
        if (hold_wait) begin
            master_waitrequest = 1'b1;
        end else if (master_write && stall_left > 0 && (acc_addr.size() % 4) == stall_word) begin
            master_waitrequest = 1'b1;
            stall_left--;
        end else begin
            master_waitrequest = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic clk_step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mon();
        acc_addr.delete();
        acc_data.delete();
        acc_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic push_vertex(input logic [ADDR_W-1:0] a, input logic [31:0] data_base);
        int n = 0;
        store_valid = 1'b1;
        addr_in     = a;
        for (int j = 0; j < 4; j++) vertex_in[j] = data_base + 32'(j);
        while (!store_ready && n < 200) begin
            clk_step();
            n++;
        end
        check("push_ready", 32'(store_ready), 32'd1);
        clk_step();
        store_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((store_busy || master_write) && n < 500) begin
            clk_step();
            n++;
        end
        check("idle_reached", 32'(store_busy), 32'd0);
        clk_step();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [ADDR_W-1:0]       addr;
        logic [31:0]             data_base;
        int                      stall_word;
        int                      stall_cycles;
        logic [3:0][ADDR_W-1:0]  exp_addr;
        int                      exp_span;
    } vec_t;

    vec_t vecs [5];
    int   exp_count = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // single vertex, no stall
        vecs[0] = '{26'h0000100, 32'hA0A0_0000, -1, 0,
                    {26'h000010C, 26'h0000108, 26'h0000104, 26'h0000100}, 3};
        // waitrequest high for 3 cycles on word 1
        vecs[1] = '{26'h0000100, 32'hB0B0_0000, 1, 3,
                    {26'h000010C, 26'h0000108, 26'h0000104, 26'h0000100}, 6};
        // address wrap at 2^26
        vecs[2] = '{26'h3FFFFFC, 32'hC0C0_0000, -1, 0,
                    {26'h0000008, 26'h0000004, 26'h0000000, 26'h3FFFFFC}, 3};
        // low address bits pass through; stall 2 cycles on word 3
        vecs[3] = '{26'h0001003, 32'hD0D0_0000, 3, 2,
                    {26'h000100F, 26'h000100B, 26'h0001007, 26'h0001003}, 5};
        // stall 1 cycle on word 0
        vecs[4] = '{26'h0000200, 32'h1234_5600, 0, 1,
                    {26'h000020C, 26'h0000208, 26'h0000204, 26'h0000200}, 3};

        // ---- reset state ----
        reset = 1'b1;
        repeat (2) clk_step();
        check("rst_write", 32'(master_write), 32'd0);
        check("rst_ready", 32'(store_ready), 32'd1);
        check("rst_busy", 32'(store_busy), 32'd0);
        check("rst_count", 32'(vertex_count), 32'd0);
        check("rst_done", 32'(vertex_done), 32'd0);
        check("rst_addr", 32'(master_address), 32'd0);
        check("rst_data", master_writedata, 32'd0);
        check("rst_read", 32'(master_read), 32'd0);
        check("rst_be", 32'(master_byteenable), 32'hF);
        reset = 1'b0;
        clk_step();

        // ---- table-driven single vertices ----
        for (int i = 0; i < 5; i++) begin
            clear_mon();
            stall_word = vecs[i].stall_word;
            stall_left = vecs[i].stall_cycles;
            push_vertex(vecs[i].addr, vecs[i].data_base);
            wait_idle();
            exp_count++;
            check($sformatf("v%0d_nwrites", i), 32'(acc_addr.size()), 32'd4);
            for (int j = 0; j < 4 && j < acc_addr.size(); j++) begin
                check($sformatf("v%0d_addr%0d", i, j), 32'(acc_addr[j]), 32'(vecs[i].exp_addr[j]));
                check($sformatf("v%0d_data%0d", i, j), acc_data[j], vecs[i].data_base + 32'(j));
            end
            if (acc_cyc.size() == 4)
                check($sformatf("v%0d_span", i), 32'(acc_cyc[3] - acc_cyc[0]), 32'(vecs[i].exp_span));
            check($sformatf("v%0d_done_pulses", i), 32'(done_cnt), 32'd1);
            check($sformatf("v%0d_count", i), 32'(vertex_count), 32'(exp_count));
        end
        stall_word = -1;
        stall_left = 0;

        // ---- FIFO full under permanent stall, then drain in order ----
        clear_mon();
        hold_wait = 1'b1;
        for (int k = 0; k < 4; k++) push_vertex(26'h0001000 + 26'(64 * k), 32'hD000_0000 | 32'(k << 8));
        check("full_ready_low", 32'(store_ready), 32'd0);
        check("full_busy", 32'(store_busy), 32'd1);
        store_valid = 1'b1;
        addr_in     = 26'h0001000 + 26'(64 * 4);
        for (int j = 0; j < 4; j++) vertex_in[j] = (32'hD000_0000 | 32'(4 << 8)) + 32'(j);
        repeat (5) clk_step();
        check("fifth_blocked_ready", 32'(store_ready), 32'd0);
        check("no_writes_while_held", 32'(acc_addr.size()), 32'd0);
        hold_wait = 1'b0;
        begin
            int n = 0;
            while (!store_ready && n < 200) begin
                clk_step();
                n++;
            end
        end
        check("fifth_ready_after_pop", 32'(store_ready), 32'd1);
        check("fifth_after_first_vertex", 32'(acc_addr.size() >= 4), 32'd1);
        clk_step();
        store_valid = 1'b0;
        wait_idle();
        exp_count += 5;
        check("fill_nwrites", 32'(acc_addr.size()), 32'd20);
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (4 * k + j < acc_addr.size()) begin
                    check($sformatf("fill_addr_v%0d_w%0d", k, j), 32'(acc_addr[4*k+j]),
                          32'(26'h0001000 + 26'(64 * k + 4 * j)));
                    check($sformatf("fill_data_v%0d_w%0d", k, j), acc_data[4*k+j],
                          (32'hD000_0000 | 32'(k << 8)) + 32'(j));
                end
            end
        end
        check("fill_done_pulses", 32'(done_cnt), 32'd5);
        check("fill_count", 32'(vertex_count), 32'(exp_count));

        // ---- two vertices back-to-back, no stalls ----
        clear_mon();
        push_vertex(26'h0002000, 32'hE000_0000);
        push_vertex(26'h0002010, 32'hE100_0000);
        wait_idle();
        exp_count += 2;
        check("b2b_nwrites", 32'(acc_addr.size()), 32'd8);
        if (acc_addr.size() == 8) begin
            for (int i = 0; i < 7; i++)
                check($sformatf("b2b_gap%0d", i), 32'(acc_cyc[i+1] - acc_cyc[i]), (i == 3) ? 32'd2 : 32'd1);
            for (int i = 0; i < 8; i++) begin
                check($sformatf("b2b_addr%0d", i), 32'(acc_addr[i]),
                      32'(26'h0002000 + 26'(16 * (i / 4) + 4 * (i % 4))));
                check($sformatf("b2b_data%0d", i), acc_data[i],
                      ((i < 4) ? 32'hE000_0000 : 32'hE100_0000) + 32'(i % 4));
            end
        end
        check("b2b_count", 32'(vertex_count), 32'(exp_count));

        // ---- reset in the middle of a vertex ----
        clear_mon();
        push_vertex(26'h0003000, 32'hF000_0000);
        begin
            int n = 0;
            while (acc_addr.size() < 2 && n < 50) begin
                clk_step();
                n++;
            end
        end
        check("mid_two_words_taken", 32'(acc_addr.size()), 32'd2);
        reset = 1'b1;
        clk_step();
        check("mid_rst_write", 32'(master_write), 32'd0);
        check("mid_rst_ready", 32'(store_ready), 32'd1);
        check("mid_rst_count", 32'(vertex_count), 32'd0);
        check("mid_rst_busy", 32'(store_busy), 32'd0);
        check("mid_rst_addr", 32'(master_address), 32'd0);
        reset = 1'b0;
        repeat (10) clk_step();
        check("mid_no_more_writes", 32'(acc_addr.size()), 32'd2);
        check("mid_no_done", 32'(done_cnt), 32'd0);
        check("mid_idle_busy", 32'(store_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
